q100_lsu: RTL and testbench

Parametrised load/store unit for the MEM stage, the successor to the fixed RV32I MEM datapath. It handles XLEN 32 or 64 and a DTCM with configurable read latency. It generates per-byte write strobes with lane-replicated store data, and sign- or zero-extends load data. It also detects misaligned or illegal accesses and stalls upstream through a ready/valid handshake while a load is in flight.

---
 rtl/q100_lsu.sv | 191 +++++++++++++++++++
 tb/tb_q100_lsu.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/q100_lsu.sv
// q100_lsu: MEM-stage load/store unit for a DTCM with configurable read latency.
// Builds byte strobes and lane-replicated store data, aligns and extends load
// data, flags misaligned/illegal requests, and stalls upstream while a load
// is in flight.
module q100_lsu #(
  parameter int XLEN            = 32,
  parameter int DTCM_ADDR_WIDTH = 16,
  parameter int DTCM_RD_LATENCY = 1,
  parameter int LEN_RD          = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic                       is_load_i,
  input  logic                       is_store_i,
  input  logic [2:0]                 funct3_i,
  input  logic [XLEN-1:0]            addr_i,
  input  logic [XLEN-1:0]            wdata_i,
  input  logic [LEN_RD-1:0]          rd_i,
  output logic [DTCM_ADDR_WIDTH-1:0] dtcm_addr_o,
  output logic                       dtcm_rd_en_o,
  output logic [XLEN/8-1:0]          dtcm_wr_be_o,
  output logic [XLEN-1:0]            dtcm_wr_data_o,
  input  logic [XLEN-1:0]            dtcm_rd_data_i,
  output logic                       resp_valid_o,
  output logic [LEN_RD-1:0]          resp_rd_o,
  output logic [XLEN-1:0]            resp_data_o,
  output logic                       err_valid_o,
  output logic [1:0]                 err_cause_o,
  output logic [XLEN-1:0]            err_addr_o
);
  localparam int         OB  = (XLEN == 64) ? 3 : 2;
  localparam int         NB  = XLEN / 8;
  localparam logic [2:0] LAT = 3'(DTCM_RD_LATENCY);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [OB-1:0]     off_q, off_d;
  logic [2:0]        f3_q, f3_d;
  logic [LEN_RD-1:0] rd_q, rd_d;
  logic              resp_valid_q, resp_valid_d;
  logic              err_valid_q, err_valid_d;
  logic [1:0]        err_cause_q, err_cause_d;
  logic [XLEN-1:0]   err_addr_q, err_addr_d;

  logic            accept, legal_ld, legal_st, illegal, misal, fault, do_ld, do_st;
  logic [OB-1:0]   off;
  logic [NB-1:0]   be_raw;
  logic [XLEN-1:0] st_data, shifted, ld_data;

  // Request decode: legality, alignment and the resulting action.
  always_comb begin
    off    = addr_i[OB-1:0];
    accept = req_valid_i && (state_q == IDLE);
    case (funct3_i)
      3'd0, 3'd1, 3'd2, 3'd4, 3'd5: legal_ld = 1'b1;
      3'd3, 3'd6:                   legal_ld = (XLEN == 64);
      default:                      legal_ld = 1'b0;
    endcase
    case (funct3_i)
      3'd0, 3'd1, 3'd2: legal_st = 1'b1;
      3'd3:             legal_st = (XLEN == 64);
      default:          legal_st = 1'b0;
    endcase
    illegal = (is_load_i && is_store_i) || (is_load_i && !legal_ld) ||
              (is_store_i && !legal_st);
    // funct3[1:0] encodes the access size for both loads and stores.
    case (funct3_i[1:0])
      2'd1:    misal = addr_i[0];
      2'd2:    misal = |addr_i[1:0];
      2'd3:    misal = |addr_i[2:0];
      default: misal = 1'b0;
    endcase
    fault = accept && (is_load_i || is_store_i) && (illegal || misal);
    do_ld = accept && is_load_i && !illegal && !misal;
    do_st = accept && is_store_i && !illegal && !misal;
  end

  // Store byte enables and lane-replicated store data.
  always_comb begin
    case (funct3_i[1:0])
      2'd0: begin
        be_raw  = NB'(1) << off;
        st_data = {NB{wdata_i[7:0]}};
      end
      2'd1: begin
        be_raw  = NB'(3) << off;
        st_data = {(XLEN/16){wdata_i[15:0]}};
      end
      2'd2: begin
        be_raw  = NB'(15) << off;
        st_data = {(XLEN/32){wdata_i[31:0]}};
      end
      default: begin
        be_raw  = '1;
        st_data = wdata_i;
      end
    endcase
  end

  // Load alignment and extension; LW sign-extends on RV64 and is a pass-through on RV32.
  always_comb begin
    shifted = dtcm_rd_data_i >> {off_q, 3'b000};
    case (f3_q)
      3'd0:    ld_data = XLEN'($signed(shifted[7:0]));
      3'd1:    ld_data = XLEN'($signed(shifted[15:0]));
      3'd2:    ld_data = XLEN'($signed(shifted[31:0]));
      3'd4:    ld_data = XLEN'(shifted[7:0]);
      3'd5:    ld_data = XLEN'(shifted[15:0]);
      3'd6:    ld_data = XLEN'(shifted[31:0]);
      default: ld_data = shifted;
    endcase
  end

  // Next-state logic for the IDLE/WAIT load sequencer and registered outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    off_d       = off_q;
    f3_d        = f3_q;
    rd_d        = rd_q;
    err_valid_d = fault;
    err_cause_d = err_cause_q;
    err_addr_d  = err_addr_q;
    if (fault) begin
      err_cause_d = illegal ? 2'd2 : (is_load_i ? 2'd0 : 2'd1);
      err_addr_d  = addr_i;
    end
    case (state_q)
      IDLE: begin
        if (do_ld) begin
          state_d = WAIT;
          cnt_d   = 3'd1;
          off_d   = off;
          f3_d    = funct3_i;
          rd_d    = rd_i;
        end
      end
      default: begin
        if (cnt_q == LAT) begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
    endcase
    // Response pulses in the cycle the counter reaches the read latency.
    resp_valid_d = (state_d == WAIT) && (cnt_d == LAT);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 3'd0;
      off_q        <= '0;
      f3_q         <= 3'd0;
      rd_q         <= '0;
      resp_valid_q <= 1'b0;
      err_valid_q  <= 1'b0;
      err_cause_q  <= 2'd0;
      err_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      off_q        <= off_d;
      f3_q         <= f3_d;
      rd_q         <= rd_d;
      resp_valid_q <= resp_valid_d;
      err_valid_q  <= err_valid_d;
      err_cause_q  <= err_cause_d;
      err_addr_q   <= err_addr_d;
    end
  end

  assign req_ready_o    = (state_q == IDLE);
  assign dtcm_addr_o    = addr_i[DTCM_ADDR_WIDTH+OB-1:OB];
  assign dtcm_rd_en_o   = do_ld;
  assign dtcm_wr_be_o   = do_st ? be_raw : '0;
  assign dtcm_wr_data_o = st_data;
  assign resp_valid_o   = resp_valid_q;
  assign resp_rd_o      = rd_q;
  assign resp_data_o    = resp_valid_q ? ld_data : '0;
  assign err_valid_o    = err_valid_q;
  assign err_cause_o    = err_cause_q;
  assign err_addr_o     = err_addr_q;
endmodule

// File: tb/tb_q100_lsu.sv
// Bench for q100_lsu: three instances (RV32 L=1, RV32 L=3, RV64 L=2) share one
// request bus; expected responses are queued at accept time and a negedge
// monitor pops and compares them against what each instance presents.
module tb_q100_lsu;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  int          cyc = 0;
  int          total = 0;
  int          passed = 0;

  logic        v_a, v_b, v_c, ld, st;
  logic [2:0]  f3;
  logic [63:0] ad, wd;
  logic [4:0]  rd;

  logic        a_rdy, a_rden, a_rv, a_ev;
  logic [3:0]  a_be;
  logic [31:0] a_wd, a_rdat, a_rdata, a_ea;
  logic [15:0] a_da;
  logic [4:0]  a_rrd;
  logic [1:0]  a_ec;

  logic        b_rdy, b_rden, b_rv, b_ev;
  logic [3:0]  b_be;
  logic [31:0] b_wd, b_rdat, b_rdata, b_ea;
  logic [15:0] b_da;
  logic [4:0]  b_rrd;
  logic [1:0]  b_ec;

  logic        c_rdy, c_rden, c_rv, c_ev;
  logic [7:0]  c_be;
  logic [63:0] c_wd, c_rdat, c_rdata, c_ea;
  logic [15:0] c_da;
  logic [4:0]  c_rrd;
  logic [1:0]  c_ec;

  typedef struct {
    int          cyc;
    logic [63:0] x;
    logic [63:0] y;
    logic [63:0] z;
  } e_t;

  e_t resp_q[3][$];
  e_t err_q[3][$];
  e_t st_q[3][$];

  q100_lsu #(.XLEN(32), .DTCM_ADDR_WIDTH(16), .DTCM_RD_LATENCY(1), .LEN_RD(5)) u_a (
    .clk(clk), .rst(rst), .req_valid_i(v_a), .req_ready_o(a_rdy),
    .is_load_i(ld), .is_store_i(st), .funct3_i(f3), .addr_i(ad[31:0]),
    .wdata_i(wd[31:0]), .rd_i(rd), .dtcm_addr_o(a_da), .dtcm_rd_en_o(a_rden),
    .dtcm_wr_be_o(a_be), .dtcm_wr_data_o(a_wd), .dtcm_rd_data_i(a_rdat),
    .resp_valid_o(a_rv), .resp_rd_o(a_rrd), .resp_data_o(a_rdata),
    .err_valid_o(a_ev), .err_cause_o(a_ec), .err_addr_o(a_ea));

  q100_lsu #(.XLEN(32), .DTCM_ADDR_WIDTH(16), .DTCM_RD_LATENCY(3), .LEN_RD(5)) u_b (
    .clk(clk), .rst(rst), .req_valid_i(v_b), .req_ready_o(b_rdy),
    .is_load_i(ld), .is_store_i(st), .funct3_i(f3), .addr_i(ad[31:0]),
    .wdata_i(wd[31:0]), .rd_i(rd), .dtcm_addr_o(b_da), .dtcm_rd_en_o(b_rden),
    .dtcm_wr_be_o(b_be), .dtcm_wr_data_o(b_wd), .dtcm_rd_data_i(b_rdat),
    .resp_valid_o(b_rv), .resp_rd_o(b_rrd), .resp_data_o(b_rdata),
    .err_valid_o(b_ev), .err_cause_o(b_ec), .err_addr_o(b_ea));

  q100_lsu #(.XLEN(64), .DTCM_ADDR_WIDTH(16), .DTCM_RD_LATENCY(2), .LEN_RD(5)) u_c (
    .clk(clk), .rst(rst), .req_valid_i(v_c), .req_ready_o(c_rdy),
    .is_load_i(ld), .is_store_i(st), .funct3_i(f3), .addr_i(ad),
    .wdata_i(wd), .rd_i(rd), .dtcm_addr_o(c_da), .dtcm_rd_en_o(c_rden),
    .dtcm_wr_be_o(c_be), .dtcm_wr_data_o(c_wd), .dtcm_rd_data_i(c_rdat),
    .resp_valid_o(c_rv), .resp_rd_o(c_rrd), .resp_data_o(c_rdata),
    .err_valid_o(c_ev), .err_cause_o(c_ec), .err_addr_o(c_ea));

  // DTCM models: data appears exactly L cycles after the read strobe, junk otherwise.
  logic [31:0] a_mem[16], b_mem[16];
  logic [63:0] c_mem[16];
  logic [31:0] a_p0, b_p[3];
  logic [63:0] c_p[2];

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    a_p0   <= a_rden ? a_mem[a_da[3:0]] : 32'hDEAD_BEEF;
    b_p[0] <= b_rden ? b_mem[b_da[3:0]] : 32'hDEAD_BEEF;
    b_p[1] <= b_p[0];
    b_p[2] <= b_p[1];
    c_p[0] <= c_rden ? c_mem[c_da[3:0]] : 64'hDEAD_BEEF_DEAD_BEEF;
    c_p[1] <= c_p[0];
  end
  assign a_rdat = a_p0;
  assign b_rdat = b_p[2];
  assign c_rdat = c_p[1];

  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", n, got, exp, cyc);
  endtask

  task automatic mon(input int id, input logic rv, input logic [4:0] rrd,
                     input logic [63:0] rdat, input logic ev, input logic [1:0] ec,
                     input logic [63:0] ea, input logic [7:0] be,
                     input logic [63:0] wdat, input logic [15:0] da);
    e_t e;
    if (rv) begin
      if (resp_q[id].size() == 0) chk($sformatf("u%0d_resp_unexpected", id), 64'(rv), 64'd0);
      else begin
        e = resp_q[id].pop_front();
        chk($sformatf("u%0d_resp_cycle", id), 64'(cyc), 64'(e.cyc));
        chk($sformatf("u%0d_resp_rd", id), 64'(rrd), e.x);
        chk($sformatf("u%0d_resp_data", id), rdat, e.y);
      end
    end
    if (ev) begin
      if (err_q[id].size() == 0) chk($sformatf("u%0d_err_unexpected", id), 64'(ev), 64'd0);
      else begin
        e = err_q[id].pop_front();
        chk($sformatf("u%0d_err_cycle", id), 64'(cyc), 64'(e.cyc));
        chk($sformatf("u%0d_err_cause", id), 64'(ec), e.x);
        chk($sformatf("u%0d_err_addr", id), ea, e.y);
      end
    end
    if (be != 8'd0) begin
      if (st_q[id].size() == 0) chk($sformatf("u%0d_store_unexpected", id), 64'(be), 64'd0);
      else begin
        e = st_q[id].pop_front();
        chk($sformatf("u%0d_store_cycle", id), 64'(cyc), 64'(e.cyc));
        chk($sformatf("u%0d_store_be", id), 64'(be), e.x);
        chk($sformatf("u%0d_store_data", id), wdat, e.y);
        chk($sformatf("u%0d_store_addr", id), 64'(da), e.z);
      end
    end
  endtask

  // Monitor: samples mid-cycle, just after the stimulus has queued its expectations.
  always @(negedge clk) begin
    #1;
    mon(0, a_rv, a_rrd, 64'(a_rdata), a_ev, a_ec, 64'(a_ea), 8'(a_be), 64'(a_wd), a_da);
    mon(1, b_rv, b_rrd, 64'(b_rdata), b_ev, b_ec, 64'(b_ea), 8'(b_be), 64'(b_wd), b_da);
    mon(2, c_rv, c_rrd, c_rdata, c_ev, c_ec, c_ea, c_be, c_wd, c_da);
  end

  // kind: 0 no-op, 1 store (e1=be, e2=data, e3=word addr), 2 load (e1=data),
  // 3 fault (e1=cause), 4 load whose response must never appear.
  task automatic req(input int id, input logic l, input logic s, input logic [2:0] f,
                     input logic [63:0] a, input logic [63:0] w, input logic [4:0] r,
                     input int kind, input logic [63:0] e1, input logic [63:0] e2,
                     input logic [63:0] e3, output int waited);
    logic rdy, rden;
    int   lat;
    e_t   e;
    ld = l; st = s; f3 = f; ad = a; wd = w; rd = r;
    v_a = (id == 0); v_b = (id == 1); v_c = (id == 2);
    waited = 0;
    rdy = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      rdy = (id == 0) ? a_rdy : (id == 1) ? b_rdy : c_rdy;
      if (rdy) break;
      waited++;
      @(posedge clk); #1;
    end
    if (!rdy) chk($sformatf("u%0d_accept_timeout", id), 64'(rdy), 64'd1);
    else begin
      rden = (id == 0) ? a_rden : (id == 1) ? b_rden : c_rden;
      chk($sformatf("u%0d_rd_en", id), 64'(rden), 64'((kind == 2) || (kind == 4)));
      lat = (id == 0) ? 1 : (id == 1) ? 3 : 2;
      e.z = 64'd0;
      case (kind)
        1: begin e.cyc = cyc; e.x = e1; e.y = e2; e.z = e3; st_q[id].push_back(e); end
        2: begin e.cyc = cyc + lat; e.x = 64'(r); e.y = e1; resp_q[id].push_back(e); end
        3: begin e.cyc = cyc + 1; e.x = e1; e.y = a; err_q[id].push_back(e); end
        default: ;
      endcase
    end
    @(posedge clk); #1;
    v_a = 1'b0; v_b = 1'b0; v_c = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w;
    for (int i = 0; i < 16; i++) begin
      a_mem[i] = 32'h0; b_mem[i] = 32'h0; c_mem[i] = 64'h0;
    end
    a_mem[0] = 32'h8000_FF7F;
    b_mem[0] = 32'h1122_3344;
    b_mem[1] = 32'hAABB_CCDD;
    c_mem[0] = 64'h8765_4321_0000_0000;
    rst = 1'b1; v_a = 1'b0; v_b = 1'b0; v_c = 1'b0; ld = 1'b0; st = 1'b0;
    f3 = 3'd0; ad = 64'd0; wd = 64'd0; rd = 5'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_a_ready", 64'(a_rdy), 64'd1);
    chk("rst_a_rd_en", 64'(a_rden), 64'd0);
    chk("rst_a_be", 64'(a_be), 64'd0);
    chk("rst_a_resp_valid", 64'(a_rv), 64'd0);
    chk("rst_a_resp_rd", 64'(a_rrd), 64'd0);
    chk("rst_a_resp_data", 64'(a_rdata), 64'd0);
    chk("rst_a_err_valid", 64'(a_ev), 64'd0);
    chk("rst_a_err_cause", 64'(a_ec), 64'd0);
    chk("rst_a_err_addr", 64'(a_ea), 64'd0);
    chk("rst_c_ready", 64'(c_rdy), 64'd1);
    chk("rst_c_be", 64'(c_be), 64'd0);
    @(posedge clk); #1;

    // RV32, L=1: stores
    req(0, 0, 1, 3'd0, 64'h103, 64'h1234_56AB, 5'd0, 1, 64'h8, 64'hABAB_ABAB, 64'h40, w);
    req(0, 0, 1, 3'd1, 64'h102, 64'h1234_5678, 5'd0, 1, 64'hC, 64'h5678_5678, 64'h40, w);
    req(0, 0, 1, 3'd2, 64'h104, 64'hCAFE_BABE, 5'd0, 1, 64'hF, 64'hCAFE_BABE, 64'h41, w);
    // RV32, L=1: loads from 0x8000_FF7F
    req(0, 1, 0, 3'd0, 64'h200, 64'd0, 5'd1, 2, 64'h0000_007F, 64'd0, 64'd0, w);
    req(0, 1, 0, 3'd4, 64'h201, 64'd0, 5'd2, 2, 64'h0000_00FF, 64'd0, 64'd0, w);
    req(0, 1, 0, 3'd1, 64'h202, 64'd0, 5'd3, 2, 64'hFFFF_8000, 64'd0, 64'd0, w);
    req(0, 1, 0, 3'd5, 64'h202, 64'd0, 5'd4, 2, 64'h0000_8000, 64'd0, 64'd0, w);
    req(0, 1, 0, 3'd0, 64'h203, 64'd0, 5'd5, 2, 64'hFFFF_FF80, 64'd0, 64'd0, w);
    req(0, 1, 0, 3'd2, 64'h200, 64'd0, 5'd6, 2, 64'h8000_FF7F, 64'd0, 64'd0, w);
    // RV32: faults and a no-op
    req(0, 1, 0, 3'd2, 64'h102, 64'd0, 5'd0, 3, 64'd0, 64'd0, 64'd0, w);
    req(0, 0, 1, 3'd1, 64'h101, 64'd0, 5'd0, 3, 64'd1, 64'd0, 64'd0, w);
    req(0, 1, 0, 3'd3, 64'h100, 64'd0, 5'd0, 3, 64'd2, 64'd0, 64'd0, w);
    req(0, 1, 1, 3'd2, 64'h101, 64'd0, 5'd0, 3, 64'd2, 64'd0, 64'd0, w);
    req(0, 0, 1, 3'd3, 64'h100, 64'd0, 5'd0, 3, 64'd2, 64'd0, 64'd0, w);
    req(0, 1, 0, 3'd7, 64'h100, 64'd0, 5'd0, 3, 64'd2, 64'd0, 64'd0, w);
    req(0, 0, 0, 3'd2, 64'h101, 64'd0, 5'd0, 0, 64'd0, 64'd0, 64'd0, w);

    // RV32, L=3: back-to-back loads, second one held from T+1
    req(1, 1, 0, 3'd2, 64'h200, 64'd0, 5'd7, 2, 64'h1122_3344, 64'd0, 64'd0, w);
    req(1, 1, 0, 3'd5, 64'h206, 64'd0, 5'd9, 2, 64'h0000_AABB, 64'd0, 64'd0, w);
    chk("b_hold_wait_cycles", 64'(w), 64'd3);

    // RV32, L=3: reset at T+2 drops the in-flight load
    req(1, 1, 0, 3'd2, 64'h200, 64'd0, 5'd10, 4, 64'd0, 64'd0, 64'd0, w);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("b_ready_after_reset", 64'(b_rdy), 64'd1);
    chk("b_resp_rd_after_reset", 64'(b_rrd), 64'd0);
    repeat (6) @(posedge clk);
    #1;

    // RV64, L=2
    req(2, 1, 0, 3'd6, 64'h104, 64'd0, 5'd1, 2, 64'h0000_0000_8765_4321, 64'd0, 64'd0, w);
    req(2, 1, 0, 3'd2, 64'h104, 64'd0, 5'd2, 2, 64'hFFFF_FFFF_8765_4321, 64'd0, 64'd0, w);
    req(2, 1, 0, 3'd3, 64'h100, 64'd0, 5'd3, 2, 64'h8765_4321_0000_0000, 64'd0, 64'd0, w);
    req(2, 1, 0, 3'd1, 64'h106, 64'd0, 5'd4, 2, 64'hFFFF_FFFF_FFFF_8765, 64'd0, 64'd0, w);
    req(2, 0, 1, 3'd3, 64'h108, 64'h0123_4567_89AB_CDEF, 5'd0, 1, 64'hFF,
        64'h0123_4567_89AB_CDEF, 64'h21, w);
    req(2, 0, 1, 3'd2, 64'h10C, 64'h0000_0000_CAFE_BABE, 5'd0, 1, 64'hF0,
        64'hCAFE_BABE_CAFE_BABE, 64'h21, w);
    req(2, 0, 1, 3'd0, 64'h10D, 64'h55, 5'd0, 1, 64'h20, 64'h5555_5555_5555_5555, 64'h21, w);
    req(2, 1, 0, 3'd3, 64'h104, 64'd0, 5'd0, 3, 64'd0, 64'd0, 64'd0, w);
    req(2, 0, 1, 3'd3, 64'h10C, 64'd0, 5'd0, 3, 64'd1, 64'd0, 64'd0, w);
    req(2, 1, 0, 3'd7, 64'h100, 64'd0, 5'd0, 3, 64'd2, 64'd0, 64'd0, w);

    repeat (8) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d_resp_pending", i), 64'(resp_q[i].size()), 64'd0);
      chk($sformatf("u%0d_err_pending", i), 64'(err_q[i].size()), 64'd0);
      chk($sformatf("u%0d_store_pending", i), 64'(st_q[i].size()), 64'd0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
